// File: rtl/input_port_sync.sv
// Multi-channel synchronised, debounced input port with per-channel change/overrun
// flags and a strobed, zero-extended read path onto the data bus.
module input_port_sync #(
  parameter int InSize      = 2,
  parameter int DataSize    = 4,
  parameter int Channels    = 2,
  parameter int SyncStages  = 2,
  parameter int DebounceCnt = 3,
  parameter int SelW        = (Channels > 1) ? $clog2(Channels) : 1
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [Channels*InSize-1:0]   INPUT,
  input  logic [SelW-1:0]              SEL,
  input  logic                         RD,
  output logic [DataSize-1:0]          INPUTD,
  output logic                         VALID,
  output logic [Channels-1:0]          CHANGED,
  output logic [Channels-1:0]          OVERRUN,
  output logic                         IRQ
);

  localparam int CntW = $clog2(DebounceCnt + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DebounceCnt);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCnt - 1);

  logic [InSize-1:0]   r_sync [Channels][SyncStages];
  logic [InSize-1:0]   r_cand [Channels];
  logic [InSize-1:0]   r_held [Channels];
  logic [CntW-1:0]     r_cnt  [Channels];
  logic [Channels-1:0] r_changed;
  logic [Channels-1:0] r_overrun;
  logic [DataSize-1:0] r_inputd;
  logic                r_valid;

  logic [InSize-1:0]   w_synced [Channels];
  logic [Channels-1:0] w_accept;
  logic [Channels-1:0] w_clear;
  logic                w_selOk;
  logic [InSize-1:0]   w_selHeld;
  logic [DataSize-1:0] w_rdData;

  always_comb begin
    w_selOk   = ({1'b0, SEL} < (SelW + 1)'(Channels));
    w_selHeld = '0;
    if (w_selOk) begin
      w_selHeld = r_held[SEL];
    end
    w_rdData                = '0;
    w_rdData[InSize-1:0]    = w_selHeld;
    w_accept                = '0;
    w_clear                 = '0;
    for (int c = 0; c < Channels; c++) begin
      w_synced[c] = r_sync[c][SyncStages-1];
      w_accept[c] = (w_synced[c] == r_cand[c]) && (r_cnt[c] == CntLast) &&
                    (r_cand[c] != r_held[c]);
      w_clear[c]  = RD && w_selOk && (SEL == SelW'(c));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int c = 0; c < Channels; c++) begin
        for (int s = 0; s < SyncStages; s++) begin
          r_sync[c][s] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < Channels; c++) begin
        r_sync[c][0] <= INPUT[c*InSize +: InSize];
        for (int s = 1; s < SyncStages; s++) begin
          r_sync[c][s] <= r_sync[c][s-1];
        end
      end
    end
  end

  // A new synced value restarts the count; acceptance fires once, on the edge the
  // value has been seen for DebounceCnt+1 consecutive cycles, then the count saturates.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int c = 0; c < Channels; c++) begin
        r_cand[c] <= '0;
        r_cnt[c]  <= '0;
        r_held[c] <= '0;
      end
    end else begin
      for (int c = 0; c < Channels; c++) begin
        if (w_synced[c] != r_cand[c]) begin
          r_cand[c] <= w_synced[c];
          r_cnt[c]  <= '0;
        end else if (r_cnt[c] < CntMax) begin
          r_cnt[c]  <= r_cnt[c] + 1'b1;
        end
        if (w_accept[c]) begin
          r_held[c] <= r_cand[c];
        end
      end
    end
  end

  // New acceptance beats a read-clear; a read on the same edge consumes the old
  // event, so it cannot count as an overrun.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_changed <= '0;
      r_overrun <= '0;
    end else begin
      r_changed <= w_accept | (r_changed & ~w_clear);
      r_overrun <= ~w_clear & (r_overrun | (w_accept & r_changed));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_inputd <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= RD;
      if (RD) begin
        r_inputd <= w_rdData;
      end
    end
  end

  assign INPUTD  = r_inputd;
  assign VALID   = r_valid;
  assign CHANGED = r_changed;
  assign OVERRUN = r_overrun;
  assign IRQ     = |r_changed;

endmodule

// File: tb/tb_input_port_sync.sv
// Self-checking bench for input_port_sync: read data is scoreboarded against a
// queue of expected words, flags are checked against scenario constants.
module tb_input_port_sync;

  logic       CLK;
  logic       RST_N;
  logic [3:0] INPUT;
  logic [0:0] SEL;
  logic       RD;
  logic [3:0] INPUTD;
  logic       VALID;
  logic [1:0] CHANGED;
  logic [1:0] OVERRUN;
  logic       IRQ;

  logic [5:0] input3;
  logic [1:0] sel3;
  logic       rd3;
  logic [3:0] inputd3;
  logic       valid3;
  logic [2:0] changed3;
  logic [2:0] overrun3;
  logic       irq3;

  int compared   = 0;
  int mismatched = 0;
  logic [3:0] expQ[$];

  input_port_sync dut (
    .CLK(CLK), .RST_N(RST_N), .INPUT(INPUT), .SEL(SEL), .RD(RD),
    .INPUTD(INPUTD), .VALID(VALID), .CHANGED(CHANGED), .OVERRUN(OVERRUN), .IRQ(IRQ)
  );

  input_port_sync #(.Channels(3)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .INPUT(input3), .SEL(sel3), .RD(rd3),
    .INPUTD(inputd3), .VALID(valid3), .CHANGED(changed3), .OVERRUN(overrun3), .IRQ(irq3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] value);
    INPUT = value;
  endtask

  // One-edge read; the expected word is queued for the VALID monitor.
  task automatic readChannel(input logic [0:0] sel, input logic [3:0] expWord);
    SEL = sel;
    RD  = 1'b1;
    expQ.push_back(expWord);
    stepCycles(1);
    RD  = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (VALID) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedValid", 32'(VALID), 32'(0));
        end else begin
          checkOutput("readData", 32'(INPUTD), 32'(expQ.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST_N  = 1'b0;
    RD     = 1'b0;
    SEL    = '0;
    INPUT  = 4'b1011;
    rd3    = 1'b0;
    sel3   = '0;
    input3 = 6'b11_01_00;

    stepCycles(3);
    checkOutput("rstInputd",  32'(INPUTD),  32'(0));
    checkOutput("rstValid",   32'(VALID),   32'(0));
    checkOutput("rstChanged", 32'(CHANGED), 32'(0));
    checkOutput("rstOverrun", 32'(OVERRUN), 32'(0));
    checkOutput("rstIrq",     32'(IRQ),     32'(0));

    RST_N = 1'b1;
    stepCycles(5);
    checkOutput("edge5Changed", 32'(CHANGED), 32'(0));
    stepCycles(1);
    checkOutput("edge6Changed", 32'(CHANGED), 32'(2'b11));
    checkOutput("edge6Irq",     32'(IRQ),     32'(1));
    checkOutput("edge6Overrun", 32'(OVERRUN), 32'(0));

    readChannel(1'b1, 4'b0010);
    checkOutput("rd1Valid",   32'(VALID),   32'(1));
    checkOutput("rd1Changed", 32'(CHANGED), 32'(2'b01));
    stepCycles(1);
    checkOutput("rd1ValidLow", 32'(VALID),  32'(0));
    checkOutput("rd1Hold",     32'(INPUTD), 32'(4'b0010));
    readChannel(1'b0, 4'b0011);
    checkOutput("rd0Changed", 32'(CHANGED), 32'(0));
    checkOutput("rd0Irq",     32'(IRQ),     32'(0));

    applyStimulus(4'b1000);
    stepCycles(8);
    checkOutput("ch0ZeroChanged", 32'(CHANGED), 32'(2'b01));
    readChannel(1'b0, 4'b0000);

    applyStimulus(4'b1011);
    stepCycles(3);
    applyStimulus(4'b1000);
    stepCycles(10);
    checkOutput("glitch3Changed", 32'(CHANGED), 32'(0));
    checkOutput("glitch3Irq",     32'(IRQ),     32'(0));

    applyStimulus(4'b1011);
    stepCycles(4);
    applyStimulus(4'b1000);
    stepCycles(1);
    checkOutput("pulse4Edge5", 32'(CHANGED), 32'(0));
    stepCycles(1);
    checkOutput("pulse4Edge6", 32'(CHANGED), 32'(2'b01));
    readChannel(1'b0, 4'b0011);
    stepCycles(3);
    checkOutput("pulseReturnChanged", 32'(CHANGED), 32'(2'b01));
    checkOutput("pulseReturnOverrun", 32'(OVERRUN), 32'(0));
    readChannel(1'b0, 4'b0000);

    applyStimulus(4'b1001);
    stepCycles(8);
    checkOutput("ovr01Changed", 32'(CHANGED), 32'(2'b01));
    applyStimulus(4'b1010);
    stepCycles(8);
    checkOutput("ovrOverrun", 32'(OVERRUN), 32'(2'b01));
    checkOutput("ovrChanged", 32'(CHANGED), 32'(2'b01));
    readChannel(1'b0, 4'b0010);
    checkOutput("ovrClrChanged", 32'(CHANGED), 32'(0));
    checkOutput("ovrClrOverrun", 32'(OVERRUN), 32'(0));

    applyStimulus(4'b1001);
    stepCycles(5);
    checkOutput("colPreChanged", 32'(CHANGED), 32'(0));
    readChannel(1'b0, 4'b0010);
    checkOutput("colChanged", 32'(CHANGED), 32'(2'b01));
    checkOutput("colOverrun", 32'(OVERRUN), 32'(0));
    readChannel(1'b0, 4'b0001);
    checkOutput("b2bValid",   32'(VALID),   32'(1));
    checkOutput("b2bChanged", 32'(CHANGED), 32'(0));

    applyStimulus(4'b1011);
    stepCycles(4);
    RST_N = 1'b0;
    #1;
    checkOutput("midRstInputd",  32'(INPUTD),  32'(0));
    checkOutput("midRstValid",   32'(VALID),   32'(0));
    checkOutput("midRstChanged", 32'(CHANGED), 32'(0));
    applyStimulus(4'b0000);
    stepCycles(2);
    RST_N = 1'b1;
    stepCycles(10);
    checkOutput("postRstChanged", 32'(CHANGED), 32'(0));
    checkOutput("postRstIrq",     32'(IRQ),     32'(0));
    readChannel(1'b0, 4'b0000);

    checkOutput("dut3Changed", 32'(changed3), 32'(3'b110));
    sel3 = 2'd2;
    rd3  = 1'b1;
    stepCycles(1);
    rd3  = 1'b0;
    checkOutput("dut3Rd2Data",    32'(inputd3),  32'(4'b0011));
    checkOutput("dut3Rd2Changed", 32'(changed3), 32'(3'b010));
    sel3 = 2'd3;
    rd3  = 1'b1;
    stepCycles(1);
    rd3  = 1'b0;
    checkOutput("oorData",    32'(inputd3),  32'(0));
    checkOutput("oorValid",   32'(valid3),   32'(1));
    checkOutput("oorChanged", 32'(changed3), 32'(3'b010));
    stepCycles(1);
    checkOutput("oorValidLow", 32'(valid3), 32'(0));

    stepCycles(2);
    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
